// File: rtl/chacha20_stream_xor_if.sv
// AXI-Stream style handshake bundle used for both the plaintext input and the
// ciphertext output of chacha20_stream_xor.
//   tdata   stream word
//   tvalid  word valid
//   tlast   last word of the message
//   tready  sink ready; a word moves when tvalid && tready
// The master modport is the word producer, the slave modport the consumer.
interface chacha20_stream_xor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/chacha20_stream_xor.sv
// chacha20_stream_xor
// Requests 512-bit keystream blocks from the chacha20 core, buffers each block
// and XORs it word by word into an AXI-Stream, so the same block encrypts and
// decrypts. Owns the per-message block counter.
//
// Ports
//   i_aclk             clock
//   i_aresetn          asynchronous active-low reset
//   i_enable           start permission, looked at only while idle
//   i_counter_init     block counter of the first block of every message
//   o_ks_start         one-cycle keystream request pulse
//   o_ks_counter       counter of the requested block, stable while waiting
//   i_keystream        keystream block, word k = i_keystream[32*k +: 32]
//   i_keystream_valid  one-cycle pulse qualifying i_keystream
//   s_axis             plaintext stream (slave)
//   m_axis             ciphertext stream (master), single output register
//   o_busy             high whenever the controller is not idle
//   o_ctr_wrap         sticky flag: block counter wrapped 0xFFFFFFFF -> 0
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no message; waits for i_enable with a plaintext word offered
// REQ     | o_ks_start high for this single cycle
// WAIT    | waiting for the core's keystream pulse
// XOR     | streaming plaintext words through the buffered block
module chacha20_stream_xor #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16
) (
    input  logic                              i_aclk,
    input  logic                              i_aresetn,
    input  logic                              i_enable,
    input  logic [31:0]                       i_counter_init,
    output logic                              o_ks_start,
    output logic [31:0]                       o_ks_counter,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]   i_keystream,
    input  logic                              i_keystream_valid,
    chacha20_stream_xor_if.slave              s_axis,
    chacha20_stream_xor_if.master             m_axis,
    output logic                              o_busy,
    output logic                              o_ctr_wrap
);

    localparam int KS_WIDTH  = DATA_WIDTH * NUM_WORDS;
    localparam int IDX_WIDTH = $clog2(NUM_WORDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_XOR
    } state_t;

    state_t                  state;
    logic [KS_WIDTH-1:0]     ks_buf;
    logic [IDX_WIDTH-1:0]    idx;
    logic [DATA_WIDTH-1:0]   ks_word;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    ks_start;
    logic [31:0]             ks_counter;
    logic                    busy;
    logic                    ctr_wrap;
    logic                    in_ready;
    logic                    accept;

    // Input may be taken only when the single output register is free or is
    // being emptied in this very cycle.
    assign in_ready = (state == ST_XOR) && (!out_valid || m_axis.tready);
    assign accept   = s_axis.tvalid && in_ready;
    assign ks_word  = ks_buf[idx * DATA_WIDTH +: DATA_WIDTH];

    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign o_ks_start    = ks_start;
    assign o_ks_counter  = ks_counter;
    assign o_busy        = busy;
    assign o_ctr_wrap    = ctr_wrap;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state      <= ST_IDLE;
            ks_buf     <= '0;
            idx        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            ks_start   <= 1'b0;
            ks_counter <= '0;
            busy       <= 1'b0;
            ctr_wrap   <= 1'b0;
        end else begin
            // Drain the output register; a word accepted below overrides this.
            if (out_valid && m_axis.tready) begin
                out_valid <= 1'b0;
            end
            ks_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_enable && s_axis.tvalid) begin
                        ks_counter <= i_counter_init;
                        ks_start   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_keystream_valid) begin
                        ks_buf <= i_keystream;
                        idx    <= '0;
                        state  <= ST_XOR;
                    end
                end

                ST_XOR: begin
                    if (accept) begin
                        out_data  <= s_axis.tdata ^ ks_word;
                        out_valid <= 1'b1;
                        out_last  <= s_axis.tlast;
                        idx       <= idx + 1'b1;
                        // End of message takes priority over end of block; the
                        // unused tail of the block is simply dropped.
                        if (s_axis.tlast) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (idx == LAST_IDX) begin
                            ks_counter <= ks_counter + 32'd1;
                            if (ks_counter == 32'hFFFF_FFFF) begin
                                ctr_wrap <= 1'b1;
                            end
                            ks_start <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
